// File: rtl/en_dff_pipe.sv
// ----------------------------------------------------------------------------
// en_dff_pipe
//   Enable-gated register pipeline. Each stage holds WIDTH data bits plus a
//   valid bit. The pipeline also has a synchronous flush and a registered
//   occupancy count of the valid stages. It is meant to be used as a
//   programmable delay/alignment stage between datapath blocks.
//
//   Optional feature: define EN_DFF_PIPE_ASSERT_EN to compile in the SVA
//   self-checks and cover points. The ports and the behaviour are the same
//   in both builds.
// ----------------------------------------------------------------------------
module en_dff_pipe #(
   parameter int              WIDTH     = 8,
   parameter int              DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           d,
   input  logic                       d_valid,
   output logic [WIDTH-1:0]           q,
   output logic                       q_valid,
   output logic [$clog2(DEPTH+1)-1:0] occ
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] data_q  [DEPTH];
   logic [WIDTH-1:0] data_d  [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;

   // Next-state selection: flush clears everything, enable shifts, otherwise hold.
   // occ cannot overflow: it can only be at DEPTH when the last stage is valid,
   // and in that case the subtraction cancels the increment.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      occ_d   = occ_q;
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = RESET_VAL;
         end
         valid_d = '0;
         occ_d   = '0;
      end else if (enable) begin
         data_d[0]  = d;
         valid_d[0] = d_valid;
         for (int i = 1; i < DEPTH; i++) begin
            data_d[i]  = data_q[i-1];
            valid_d[i] = valid_q[i-1];
         end
         occ_d = occ_q + OCC_W'(d_valid) - OCC_W'(valid_q[DEPTH-1]);
      end
   end

   // Stage registers. Reset is asynchronous and takes priority over everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= RESET_VAL;
         end
         valid_q <= '0;
         occ_q   <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         occ_q   <= occ_d;
      end
   end

   // The outputs come straight from the last stage, so no path from an input
   // reaches an output without passing through a register.
   assign q       = data_q[DEPTH-1];
   assign q_valid = valid_q[DEPTH-1];
   assign occ     = occ_q;

`ifdef EN_DFF_PIPE_ASSERT_EN
   a_reset: assert property (@(posedge clk) disable iff (reset)
      reset |=> (q == RESET_VAL && !q_valid && occ == '0));

   a_flush: assert property (@(posedge clk) disable iff (reset)
      flush |=> (!q_valid && occ == '0));

   a_hold: assert property (@(posedge clk) disable iff (reset)
      (!enable && !flush) |=> $stable({q, q_valid, occ}));

   a_delay: assert property (@(posedge clk) disable iff (reset)
      (enable && !flush) |=> (data_q[0] == $past(d) && valid_q[0] == $past(d_valid)));

   // Each later stage must hold exactly what its predecessor held before the shift.
   for (genvar g = 1; g < DEPTH; g++) begin : g_shadow
      a_stage: assert property (@(posedge clk) disable iff (reset)
         (enable && !flush) |=> (data_q[g] == $past(data_q[g-1]) &&
                                 valid_q[g] == $past(valid_q[g-1])));
   end

   a_occ: assert property (@(posedge clk) disable iff (reset)
      (occ_q == OCC_W'($countones(valid_q)) && occ_q <= OCC_W'(DEPTH)));

   c_full: cover property (@(posedge clk) disable iff (reset)
      occ_q == OCC_W'(DEPTH));

   c_flush_full: cover property (@(posedge clk) disable iff (reset)
      flush && occ_q == OCC_W'(DEPTH));
`else
   // Checks are not compiled in, so no assertion or shadow logic exists here.
`endif

endmodule

// File: tb/tb_en_dff_pipe.sv
// ----------------------------------------------------------------------------
// tb_en_dff_pipe
//   Self-checking bench for en_dff_pipe. It drives a DEPTH=4 instance (the
//   main target) and a DEPTH=1 instance with a non-zero RESET_VAL from the
//   same stimulus. Expected values come from a vector table, from hand-written
//   sequences and from a data scoreboard.
// ----------------------------------------------------------------------------
module tb_en_dff_pipe;

   typedef struct {
      logic       en;
      logic       fl;
      logic       dv;
      logic [7:0] d;
      logic [7:0] q;
      logic       qv;
      logic [2:0] occ;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       flush;
   logic       dValid;
   logic [7:0] dIn;

   logic [7:0] q4;
   logic       qv4;
   logic [2:0] occ4;
   logic [7:0] q1;
   logic       qv1;
   logic [0:0] occ1;

   logic [7:0] m1Q;
   logic       m1V;

   logic [7:0] sb [$];
   vec_t       vecs [$];

   int errors = 0;
   int checks = 0;

   en_dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
      .clk(clk), .reset(reset), .enable(enable), .flush(flush),
      .d(dIn), .d_valid(dValid), .q(q4), .q_valid(qv4), .occ(occ4)
   );

   en_dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h5A)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .flush(flush),
      .d(dIn), .d_valid(dValid), .q(q1), .q_valid(qv1), .occ(occ1)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic addVec(input logic en, input logic fl, input logic dv, input logic [7:0] d,
                         input logic [7:0] q, input logic qv, input logic [2:0] occ);
      vec_t v;
      v.en = en; v.fl = fl; v.dv = dv; v.d = d; v.q = q; v.qv = qv; v.occ = occ;
      vecs.push_back(v);
   endtask

   // Drive on the falling edge, take one rising edge, then sample 1 unit later.
   // The DEPTH=1 instance is checked here against its one-stage expectation.
   task automatic applyStimulus(input logic en, input logic fl, input logic dv, input logic [7:0] dat);
      @(negedge clk);
      enable = en;
      flush  = fl;
      dValid = dv;
      dIn    = dat;
      @(posedge clk);
      if (fl) begin
         m1Q = 8'h5A;
         m1V = 1'b0;
      end else if (en) begin
         m1Q = dat;
         m1V = dv;
      end
      #1;
      checkOutput("d1_q", q1, m1Q);
      checkOutput("d1_qv", qv1, m1V);
      checkOutput("d1_occ", occ1, m1V);
   endtask

   // A single scoreboard step: push valid data at an enabled edge and pop it
   // when it shows up at q. occ must equal the items still in flight plus q.
   task automatic sbStep(input logic en, input logic fl, input logic dv, input logic [7:0] dat);
      applyStimulus(en, fl, dv, dat);
      if (fl) begin
         sb.delete();
         checkOutput("sb_flush_qv", qv4, 0);
      end else if (en) begin
         if (dv) sb.push_back(dat);
         if (qv4) begin
            checkOutput("sb_nonempty", int'(sb.size() != 0), 1);
            if (sb.size() != 0) checkOutput("sb_data", q4, sb.pop_front());
         end
      end
      checkOutput("sb_occ", occ4, sb.size() + int'(qv4));
   endtask

   initial begin
      // Table rows: en, fl, dv, d, expected q, q_valid, occ
      // basic stream 11..44, then drain
      addVec(1,0,1,8'h11, 8'h00,0,3'd1);
      addVec(1,0,1,8'h22, 8'h00,0,3'd2);
      addVec(1,0,1,8'h33, 8'h00,0,3'd3);
      addVec(1,0,1,8'h44, 8'h11,1,3'd4);
      addVec(1,0,0,8'h00, 8'h22,1,3'd3);
      addVec(1,0,0,8'h00, 8'h33,1,3'd2);
      addVec(1,0,0,8'h00, 8'h44,1,3'd1);
      addVec(1,0,0,8'h00, 8'h00,0,3'd0);
      // alternating d_valid
      addVec(1,0,1,8'h01, 8'h00,0,3'd1);
      addVec(1,0,0,8'h02, 8'h00,0,3'd1);
      addVec(1,0,1,8'h03, 8'h00,0,3'd2);
      addVec(1,0,0,8'h04, 8'h01,1,3'd2);
      addVec(1,0,0,8'h00, 8'h02,0,3'd1);
      addVec(1,0,0,8'h00, 8'h03,1,3'd1);
      addVec(1,0,0,8'h00, 8'h04,0,3'd0);
      addVec(1,0,0,8'h00, 8'h00,0,3'd0);
      // stream with three disabled cycles after the second edge
      addVec(1,0,1,8'h11, 8'h00,0,3'd1);
      addVec(1,0,1,8'h22, 8'h00,0,3'd2);
      addVec(0,0,1,8'hEE, 8'h00,0,3'd2);
      addVec(0,0,1,8'hEE, 8'h00,0,3'd2);
      addVec(0,0,1,8'hEE, 8'h00,0,3'd2);
      addVec(1,0,1,8'h33, 8'h00,0,3'd3);
      addVec(1,0,1,8'h44, 8'h11,1,3'd4);
      addVec(0,0,1,8'h77, 8'h11,1,3'd4);
      // flush with enable on a full pipe; FF must never emerge
      addVec(1,1,1,8'hFF, 8'h00,0,3'd0);
      addVec(1,0,0,8'h00, 8'h00,0,3'd0);
      addVec(1,0,0,8'h00, 8'h00,0,3'd0);
      addVec(1,0,0,8'h00, 8'h00,0,3'd0);
      addVec(1,0,0,8'h00, 8'h00,0,3'd0);
      // flush without enable; 55 must never emerge
      addVec(1,0,1,8'h55, 8'h00,0,3'd1);
      addVec(0,1,1,8'h66, 8'h00,0,3'd0);
      addVec(1,0,0,8'h00, 8'h00,0,3'd0);
      addVec(1,0,0,8'h00, 8'h00,0,3'd0);
      addVec(1,0,0,8'h00, 8'h00,0,3'd0);
      addVec(1,0,0,8'h00, 8'h00,0,3'd0);

      // power-on reset
      reset  = 1'b1;
      enable = 1'b0;
      flush  = 1'b0;
      dValid = 1'b0;
      dIn    = 8'h00;
      m1Q    = 8'h5A;
      m1V    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_q", q4, 8'h00);
      checkOutput("rst_qv", qv4, 0);
      checkOutput("rst_occ", occ4, 0);
      checkOutput("rst_d1_q", q1, 8'h5A);
      @(negedge clk);
      reset = 1'b0;

      // table-driven section
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].en, vecs[i].fl, vecs[i].dv, vecs[i].d);
         checkOutput($sformatf("vec%0d_q", i), q4, vecs[i].q);
         checkOutput($sformatf("vec%0d_qv", i), qv4, vecs[i].qv);
         checkOutput($sformatf("vec%0d_occ", i), occ4, vecs[i].occ);
      end

      // fill until A5 is at q, then an asynchronous reset mid-cycle
      applyStimulus(1, 0, 1, 8'hA5);
      repeat (3) applyStimulus(1, 0, 0, 8'h00);
      checkOutput("a5_q", q4, 8'hA5);
      checkOutput("a5_qv", qv4, 1);
      checkOutput("a5_occ", occ4, 1);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_rst_q", q4, 8'h00);
      checkOutput("async_rst_qv", qv4, 0);
      checkOutput("async_rst_occ", occ4, 0);
      checkOutput("async_rst_d1_q", q1, 8'h5A);
      checkOutput("async_rst_d1_qv", qv1, 0);
      m1Q = 8'h5A;
      m1V = 1'b0;
      #1 reset = 1'b0;

      // randomised scoreboard run
      for (int n = 0; n < 300; n++) begin
         sbStep(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)));
      end
      repeat (4) sbStep(1, 0, 0, 8'h00);
      checkOutput("sb_drained", sb.size(), 0);
      checkOutput("sb_drained_occ", occ4, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
